// File: rtl/mips_pkg.sv
// Shared widths, HALT marker and loader state encoding.
// CHECK state exists only with PROGRAM_LOADER_CHECKSUM_EN defined.
package mips_pkg;

    localparam int INSTRUCTION_LENGTH = 32;
    localparam int PC_LENGTH          = 32;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECEIVE = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        CHECK   = 3'd4
`endif
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word shift register with byte index.
// word presents the completed word in the same cycle the last byte arrives.
module byte_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] word,
    output logic             word_ready
);

    localparam int BYTES = WIDTH / 8;
    localparam int IW    = $clog2(BYTES);

    logic [WIDTH-9:0] shift;
    logic [IW-1:0]    index;

    assign word       = {shift, data};
    assign word_ready = valid && (index == IW'(BYTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift <= '0;
            index <= '0;
        end else if (clear) begin
            shift <= '0;
            index <= '0;
        end else if (valid) begin
            shift <= word[WIDTH-9:0];
            index <= word_ready ? '0 : index + IW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory, then enables the core.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
    parameter int INSTRUCTION_LENGTH = mips_pkg::INSTRUCTION_LENGTH,
    parameter int PC_LENGTH          = mips_pkg::PC_LENGTH,
    parameter int MEM_WORDS          = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_load,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [INSTRUCTION_LENGTH-1:0] instruction_to_write,
    output logic [PC_LENGTH-1:0]          address_to_write,
    output logic                          mem_wr_en,
    output logic                          mips_enable,
    output logic [PC_LENGTH-1:0]          word_count,
    output logic                          overflow_error
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic                          checksum_error
`endif
);

    import mips_pkg::*;

    loader_state_t state;

    logic [INSTRUCTION_LENGTH-1:0] word;
    logic                          word_ready;
    logic                          asm_valid;
    logic [PC_LENGTH-1:0]          next_count;
    logic                          halt_wr;
    logic                          full_wr;
    logic                          stop_wr;

    assign next_count = word_count + PC_LENGTH'(1);
    assign halt_wr    = (instruction_to_write == INSTRUCTION_LENGTH'(HALT_WORD));
    assign full_wr    = (next_count == PC_LENGTH'(MEM_WORDS));
    assign stop_wr    = halt_wr || full_wr;

    // A byte landing in the final WRITE of a load belongs to no word.
    assign asm_valid = rx_valid &&
                       ((state == RECEIVE) || ((state == WRITE) && !stop_wr));

    byte_assembler #(
        .WIDTH (INSTRUCTION_LENGTH)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .valid      (asm_valid),
        .data       (rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (start_load) begin
            csum <= '0;
        end else if (asm_valid) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            instruction_to_write <= '0;
            address_to_write     <= '0;
            mem_wr_en            <= 1'b0;
            mips_enable          <= 1'b0;
            word_count           <= '0;
            overflow_error       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum_error       <= 1'b0;
`endif
        end else begin
            mem_wr_en <= 1'b0;
            if (start_load) begin
                state                <= RECEIVE;
                instruction_to_write <= '0;
                address_to_write     <= '0;
                mips_enable          <= 1'b0;
                word_count           <= '0;
                overflow_error       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                checksum_error       <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    RECEIVE: begin
                        if (word_ready) begin
                            state                <= WRITE;
                            mem_wr_en            <= 1'b1;
                            instruction_to_write <= word;
                            address_to_write     <= {word_count[PC_LENGTH-3:0], 2'b00};
                        end
                    end
                    WRITE: begin
                        word_count <= next_count;
                        if (halt_wr) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state       <= CHECK;
`else
                            state       <= DONE;
                            mips_enable <= 1'b1;
`endif
                        end else if (full_wr) begin
                            state          <= IDLE;
                            overflow_error <= 1'b1;
                        end else begin
                            state <= RECEIVE;
                        end
                    end
                    DONE: begin
                    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (rx_valid) begin
                            if (rx_data == csum) begin
                                state       <= DONE;
                                mips_enable <= 1'b1;
                            end else begin
                                state          <= IDLE;
                                checksum_error <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a 4-word instance for overflow.
// Define PROGRAM_LOADER_CHECKSUM_EN to also exercise the checksum byte.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start_load;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [31:0] instruction_to_write;
    logic [31:0] address_to_write;
    logic        mem_wr_en;
    logic        mips_enable;
    logic [31:0] word_count;
    logic        overflow_error;

    logic [31:0] s_instruction_to_write;
    logic [31:0] s_address_to_write;
    logic        s_mem_wr_en;
    logic        s_mips_enable;
    logic [31:0] s_word_count;
    logic        s_overflow_error;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic        checksum_error;
    logic        s_checksum_error;
    logic [7:0]  xsum;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] sa[$];
    logic [31:0] sd[$];

    program_loader dut (
        .clk                  (clk),
        .reset                (reset),
        .start_load           (start_load),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .instruction_to_write (instruction_to_write),
        .address_to_write     (address_to_write),
        .mem_wr_en            (mem_wr_en),
        .mips_enable          (mips_enable),
        .word_count           (word_count),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .checksum_error       (checksum_error),
`endif
        .overflow_error       (overflow_error)
    );

    program_loader #(
        .MEM_WORDS (4)
    ) dut_small (
        .clk                  (clk),
        .reset                (reset),
        .start_load           (start_load),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .instruction_to_write (s_instruction_to_write),
        .address_to_write     (s_address_to_write),
        .mem_wr_en            (s_mem_wr_en),
        .mips_enable          (s_mips_enable),
        .word_count           (s_word_count),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .checksum_error       (s_checksum_error),
`endif
        .overflow_error       (s_overflow_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wa.push_back(address_to_write);
            wd.push_back(instruction_to_write);
        end
        if (s_mem_wr_en) begin
            sa.push_back(s_address_to_write);
            sd.push_back(s_instruction_to_write);
        end
        if (reset) begin
            check("excl", {31'd0, mem_wr_en & mips_enable}, 32'd0);
        end
    end

    task automatic clearq();
        wa.delete();
        wd.delete();
        sa.delete();
        sd.delete();
    endtask

    task automatic start();
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xsum = 8'h00;
`endif
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xsum = xsum ^ b;
`endif
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) begin
            send(w[i*8 +: 8], gap);
        end
    endtask

    task automatic finish_prog();
        @(negedge clk);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(xsum, 0);
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input int i,
                          input logic [31:0] a, input logic [31:0] d);
        if (i < wa.size()) begin
            check({tag, "_addr"}, wa[i], a);
            check({tag, "_data"}, wd[i], d);
        end else begin
            check({tag, "_count"}, 32'(wa.size()), 32'(i + 1));
        end
    endtask

    task automatic chk_swr(input string tag, input int i,
                           input logic [31:0] a, input logic [31:0] d);
        if (i < sa.size()) begin
            check({tag, "_addr"}, sa[i], a);
            check({tag, "_data"}, sd[i], d);
        end else begin
            check({tag, "_count"}, 32'(sa.size()), 32'(i + 1));
        end
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b0;
        start_load = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xsum = 8'h00;
`endif
        #2;
        check("rst_wr", {31'd0, mem_wr_en}, 32'd0);
        check("rst_en", {31'd0, mips_enable}, 32'd0);
        check("rst_wc", word_count, 32'd0);
        check("rst_addr", address_to_write, 32'd0);
        check("rst_instr", instruction_to_write, 32'd0);
        check("rst_ovf", {31'd0, overflow_error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // basic two-word program
        clearq();
        start();
        send_word(32'h2008_0005, 0);
        send_word(32'hFFFF_FFFF, 0);
        finish_prog();
        check("t1_nwr", 32'(wa.size()), 32'd2);
        chk_wr("t1_w0", 0, 32'h0, 32'h2008_0005);
        chk_wr("t1_w1", 1, 32'h4, 32'hFFFF_FFFF);
        check("t1_wc", word_count, 32'd2);
        check("t1_en", {31'd0, mips_enable}, 32'd1);
        check("t1_wr", {31'd0, mem_wr_en}, 32'd0);

        // reset in the middle of a word
        clearq();
        start();
        send(8'hAA, 0);
        send(8'hBB, 0);
        reset = 1'b0;
        #2;
        check("t2_wr", {31'd0, mem_wr_en}, 32'd0);
        check("t2_instr", instruction_to_write, 32'd0);
        check("t2_addr", address_to_write, 32'd0);
        check("t2_wc", word_count, 32'd0);
        check("t2_en", {31'd0, mips_enable}, 32'd0);
        @(negedge clk);
        check("t2_nwr_rst", 32'(wa.size()), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        start();
        send_word(32'h1122_3344, 1);
        send_word(32'hFFFF_FFFF, 0);
        finish_prog();
        check("t2_nwr", 32'(wa.size()), 32'd2);
        chk_wr("t2_w0", 0, 32'h0, 32'h1122_3344);
        chk_wr("t2_w1", 1, 32'h4, 32'hFFFF_FFFF);
        check("t2_en2", {31'd0, mips_enable}, 32'd1);

        // back-to-back bytes across WRITE cycles
        clearq();
        start();
        send_word(32'h0102_0304, 0);
        send_word(32'hA0B0_C0D0, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'hFFFF_FFFF, 0);
        finish_prog();
        check("t3_nwr", 32'(wa.size()), 32'd4);
        chk_wr("t3_w0", 0, 32'h0, 32'h0102_0304);
        chk_wr("t3_w1", 1, 32'h4, 32'hA0B0_C0D0);
        chk_wr("t3_w2", 2, 32'h8, 32'hDEAD_BEEF);
        chk_wr("t3_w3", 3, 32'hC, 32'hFFFF_FFFF);
        check("t3_wc", word_count, 32'd4);

        // reload from DONE
        clearq();
        start();
        check("t4_en_drop", {31'd0, mips_enable}, 32'd0);
        check("t4_wc_clr", word_count, 32'd0);
        send_word(32'h1234_5678, 0);
        send_word(32'hFFFF_FFFF, 0);
        finish_prog();
        check("t4_nwr", 32'(wa.size()), 32'd2);
        chk_wr("t4_w0", 0, 32'h0, 32'h1234_5678);
        check("t4_wc", word_count, 32'd2);
        check("t4_en", {31'd0, mips_enable}, 32'd1);

        // restart during RECEIVE discards the partial word
        clearq();
        start();
        send(8'h55, 0);
        send(8'h66, 0);
        start();
        send_word(32'hCAFE_BABE, 0);
        send_word(32'hFFFF_FFFF, 0);
        finish_prog();
        check("t5_nwr", 32'(wa.size()), 32'd2);
        chk_wr("t5_w0", 0, 32'h0, 32'hCAFE_BABE);
        chk_wr("t5_w1", 1, 32'h4, 32'hFFFF_FFFF);

        // overflow on the 4-word instance
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clearq();
        start();
        for (int n = 1; n <= 5; n++) begin
            send_word(32'(n), 0);
        end
        repeat (4) @(negedge clk);
        check("t6_nwr", 32'(sa.size()), 32'd4);
        chk_swr("t6_w0", 0, 32'h0, 32'h1);
        chk_swr("t6_w3", 3, 32'hC, 32'h4);
        check("t6_ovf", {31'd0, s_overflow_error}, 32'd1);
        check("t6_en", {31'd0, s_mips_enable}, 32'd0);
        check("t6_wc", s_word_count, 32'd4);
        check("t6_big_ovf", {31'd0, overflow_error}, 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // checksum accepted
        clearq();
        start();
        send_word(32'h0000_0000, 0);
        send_word(32'hFFFF_FFFF, 0);
        @(negedge clk);
        check("ck_wait_en", {31'd0, mips_enable}, 32'd0);
        send(8'h00, 0);
        repeat (2) @(negedge clk);
        check("ck_ok_en", {31'd0, mips_enable}, 32'd1);
        check("ck_ok_err", {31'd0, checksum_error}, 32'd0);

        // checksum rejected
        start();
        send_word(32'h0000_0000, 0);
        send_word(32'hFFFF_FFFF, 0);
        @(negedge clk);
        send(8'h01, 0);
        repeat (2) @(negedge clk);
        check("ck_bad_en", {31'd0, mips_enable}, 32'd0);
        check("ck_bad_err", {31'd0, checksum_error}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter INSTRUCTION_LENGTH, default 32: instruction word width in bits.
REQ-002 SHALL have parameter PC_LENGTH, default 32: address width in bits.
REQ-003 SHALL have parameter MEM_WORDS, default 256: instruction memory capacity in words.
REQ-004 Ports SHALL be:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- start_load  input  1  single-cycle request to begin a new load.
- rx_data  input  8  incoming program byte.
- rx_valid  input  1  one-cycle strobe qualifying rx_data.
- instruction_to_write  output  INSTRUCTION_LENGTH  assembled word for instruction memory.
- address_to_write  output  PC_LENGTH  byte address for that word.
- mem_wr_en  output  1  one-cycle instruction memory write strobe.
- mips_enable  output  1  high only when the program is loaded and the core may run.
- word_count  output  PC_LENGTH  number of words written in the current load.
- overflow_error  output  1  sticky flag: program exceeded MEM_WORDS.

Function
REQ-005 FSM SHALL have states IDLE, RECEIVE, WRITE and DONE.
REQ-006 IDLE: outputs inactive; start_load -> RECEIVE; clears word_count, address, byte index and overflow_error.
REQ-007 RECEIVE: each rx_valid shifts rx_data in big-endian (first byte -> bits 31:24); 4th byte -> WRITE on the next edge.
REQ-008 WRITE SHALL last exactly one cycle, with mem_wr_en=1, address_to_write=word_count*4 and instruction_to_write=assembled word.
REQ-009 After WRITE, word_count SHALL increment by 1.
REQ-010 After WRITE, next state SHALL be DONE if the word was HALT_WORD (32'hFFFF_FFFF); otherwise RECEIVE.
REQ-011 The HALT word SHALL itself be written to memory.
REQ-012 rx_valid arriving during WRITE SHALL be accepted as byte 0 of the next word; no byte is lost.
REQ-013 DONE: mips_enable=1, mem_wr_en=0; rx_valid ignored; start_load -> RECEIVE with mips_enable deasserted on the same edge.
REQ-014 If word_count reaches MEM_WORDS without HALT, overflow_error SHALL set, no further writes SHALL occur, and the FSM SHALL go to IDLE.
REQ-015 start_load during RECEIVE or WRITE SHALL restart the load: counters cleared; a WRITE in progress completes first.
REQ-016 Address arithmetic SHALL be PC_LENGTH wide, step 4; no wrap is possible because REQ-014 bounds it.
REQ-017 mem_wr_en and mips_enable SHALL never be high in the same cycle.

Reset
REQ-018 reset low SHALL immediately force IDLE and zero all outputs, counters and the assembly register, independent of clk.
REQ-019 Reset asserted mid-load SHALL discard the partial word with no write strobe.

Configuration
REQ-020 With PROGRAM_LOADER_CHECKSUM_EN defined:
- After HALT, the FSM SHALL enter state CHECK and await one byte.
- That byte SHALL equal the XOR of all program bytes; a mismatch sets a sticky output checksum_error and the FSM returns to IDLE with mips_enable=0.
- A match -> DONE.
REQ-021 Without PROGRAM_LOADER_CHECKSUM_EN, the CHECK state, the checksum_error port and the XOR logic SHALL be absent; HALT -> DONE directly.

Structure
REQ-022 Shared package mips_pkg SHALL hold INSTRUCTION_LENGTH, PC_LENGTH, HALT_WORD and the loader state encoding.
REQ-023 Sub-module byte_assembler SHALL provide the 4-byte shift register and byte index, with clear/valid inputs and a word_ready output.

Verification
REQ-024 start_load, bytes 20 08 00 05 FF FF FF FF -> mem_wr_en at 0x0 (0x20080005) and at 0x4 (0xFFFFFFFF), word_count=2, then mips_enable=1.
REQ-025 Reset low after 2 bytes of a word -> no write, all outputs 0; a fresh start_load then loads correctly from address 0.
REQ-026 MEM_WORDS=4, 5 non-HALT words -> 4 writes (0x0-0xC), overflow_error=1, no 5th write, mips_enable=0.
REQ-027 rx_valid in the WRITE cycle (back-to-back bytes every clock) -> all words written correctly and consecutively.
REQ-028 start_load in DONE -> mips_enable drops on the next edge; the new program overwrites from address 0.
REQ-029 With PROGRAM_LOADER_CHECKSUM_EN, program 00000000 FFFFFFFF:
- Checksum byte 0x00 -> mips_enable=1.
- Checksum byte 0x01 -> checksum_error=1, mips_enable=0.
